// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned DEFAULT_DEPTH = 1024;

  // Host-port handshake states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } ld_state_t;

  // True when a 30-bit word index falls inside an array of `depth` words.
  function automatic logic word_in_range(input logic [29:0] word, input int unsigned depth);
    return word < 30'(depth);
  endfunction

endpackage

// File: rtl/ram_2r1w.sv
// Word array with one synchronous write port and two asynchronous read ports.
module ram_2r1w
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [WORD_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [WORD_W-1:0] rdata_b
);

  // Guards indices past DEPTH when DEPTH is not a power of two.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];

  // Single write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < DEPTH_W)) begin
      mem[waddr] <= wdata;
    end
  end

  // Two independent combinational read ports.
  assign rdata_a = ({1'b0, raddr_a} < DEPTH_W) ? mem[raddr_a] : '0;
  assign rdata_b = ({1'b0, raddr_b} < DEPTH_W) ? mem[raddr_b] : '0;

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: processor port always wins, host port uses idle cycles.
module data_memory_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memw_m,
  input  logic [WORD_W-1:0] m_address,
  input  logic [WORD_W-1:0] m_data,
  output logic [WORD_W-1:0] data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              ld_write,
  input  logic [AW-1:0]     ld_addr,
  input  logic [WORD_W-1:0] ld_wdata,
  output logic              ld_rvalid,
  output logic [WORD_W-1:0] ld_rdata,
  output logic              addr_err
);

  ld_state_t state_q, state_d;

  logic              req_write_q;
  logic [AW-1:0]     req_addr_q;
  logic [WORD_W-1:0] req_wdata_q;

  logic              ld_rvalid_q, ld_rvalid_d;
  logic [WORD_W-1:0] ld_rdata_q, ld_rdata_d;
  logic              addr_err_q;

  logic              latch_req_c;
  logic              host_we_c;
  logic              grant_c;

  logic [29:0]       proc_word;
  logic [AW-1:0]     proc_idx;
  logic              proc_in_range;
  logic              proc_we;
  logic              unused_byte_bits;

  logic              ram_we;
  logic [AW-1:0]     ram_waddr;
  logic [WORD_W-1:0] ram_wdata;
  logic [WORD_W-1:0] proc_rdata;
  logic [WORD_W-1:0] host_rdata;

  // Byte address decode; range check uses the full word address so aliases are caught.
  assign proc_word        = m_address[31:2];
  assign proc_idx         = m_address[AW+1:2];
  assign proc_in_range    = word_in_range(proc_word, DEPTH);
  assign proc_we          = memw_m && proc_in_range;
  assign unused_byte_bits = ^m_address[1:0];

  // Write-port arbitration: processor has priority, host writes only when memw_m is low.
  assign ram_we    = proc_we || host_we_c;
  assign ram_waddr = memw_m ? proc_idx : req_addr_q;
  assign ram_wdata = memw_m ? m_data   : req_wdata_q;

  ram_2r1w #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr_a (proc_idx),
    .rdata_a (proc_rdata),
    .raddr_b (req_addr_q),
    .rdata_b (host_rdata)
  );

  // Processor read path is combinational and returns zero out of range.
  assign data = proc_in_range ? proc_rdata : '0;

  // Host FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Host FSM next state and handshake decode.
  always_comb begin
    state_d     = state_q;
    latch_req_c = 1'b0;
    host_we_c   = 1'b0;
    grant_c     = 1'b0;
    ld_rvalid_d = 1'b0;
    ld_rdata_d  = ld_rdata_q;
    case (state_q)
      IDLE: begin
        if (ld_valid && !memw_m) begin
          latch_req_c = 1'b1;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (req_write_q) begin
          // A processor write in this cycle holds the host write for a retry.
          if (!memw_m) begin
            grant_c   = 1'b1;
            host_we_c = 1'b1;
            state_d   = IDLE;
          end
        end else begin
          grant_c     = 1'b1;
          ld_rdata_d  = host_rdata;
          ld_rvalid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Host request latch, captured on the IDLE to GRANT transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else if (latch_req_c) begin
      req_write_q <= ld_write;
      req_addr_q  <= ld_addr;
      req_wdata_q <= ld_wdata;
    end
  end

  // Registered host read response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_rvalid_q <= 1'b0;
      ld_rdata_q  <= '0;
    end else begin
      ld_rvalid_q <= ld_rvalid_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_err_q <= 1'b0;
    end else if (memw_m && !proc_in_range) begin
      addr_err_q <= 1'b1;
    end
  end

  // ld_ready must reflect this cycle's memw_m, so it is a decode of the state register.
  assign ld_ready  = grant_c;
  assign ld_rvalid = ld_rvalid_q;
  assign ld_rdata  = ld_rdata_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder with a host-read scoreboard.
module tb_data_memory_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          memw_m;
  logic [31:0]   m_address;
  logic [31:0]   m_data;
  logic [31:0]   data;
  logic          ld_valid;
  logic          ld_ready;
  logic          ld_write;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_wdata;
  logic          ld_rvalid;
  logic [31:0]   ld_rdata;
  logic          addr_err;

  int errors = 0;
  int checks = 0;
  int rvalid_count = 0;

  logic [31:0] model [int];
  logic [31:0] exp_q [$];

  data_memory_responder #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .memw_m    (memw_m),
    .m_address (m_address),
    .m_data    (m_data),
    .data      (data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_write  (ld_write),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_rvalid (ld_rvalid),
    .ld_rdata  (ld_rdata),
    .addr_err  (addr_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ld_rvalid === 1'b1) rvalid_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic proc_write(input logic [31:0] a, input logic [31:0] d);
    memw_m    = 1'b1;
    m_address = a;
    m_data    = d;
    tick();
    memw_m = 1'b0;
    if (a[31:2] < 30'(DEPTH)) model[int'(a[AW+1:2])] = d;
  endtask

  // Drive a host request; reads push their expected data to the scoreboard.
  task automatic host_issue(input logic wr, input logic [AW-1:0] a, input logic [31:0] wd);
    ld_valid = 1'b1;
    ld_write = wr;
    ld_addr  = a;
    ld_wdata = wd;
    if (wr) model[int'(a)] = wd;
    else    exp_q.push_back(model[int'(a)]);
  endtask

  // Cycles until ld_ready is seen (-1 on timeout); drops ld_valid once accepted.
  task automatic wait_ready(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      @(negedge clk);
      if (ld_ready === 1'b1) begin
        lat = i;
        break;
      end
    end
    ld_valid = 1'b0;
  endtask

  task automatic wait_rvalid(output int lat, output logic [31:0] rd);
    lat = -1;
    rd  = '0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      @(negedge clk);
      if (ld_rvalid === 1'b1) begin
        lat = i;
        rd  = ld_rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; memw_m = 1'b0; m_address = '0; m_data = '0;
    ld_valid = 1'b0; ld_write = 1'b0; ld_addr = '0; ld_wdata = '0;
    repeat (2) tick();
    @(negedge clk);
    checks++; if (ld_ready !== 1'b0)   begin errors++; $display("FAIL reset_ld_ready: got %b want 0", ld_ready); end
    checks++; if (ld_rvalid !== 1'b0)  begin errors++; $display("FAIL reset_ld_rvalid: got %b want 0", ld_rvalid); end
    checks++; if (ld_rdata !== 32'h0)  begin errors++; $display("FAIL reset_ld_rdata: got %h want 0", ld_rdata); end
    checks++; if (addr_err !== 1'b0)   begin errors++; $display("FAIL reset_addr_err: got %b want 0", addr_err); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_proc_rw();
    logic [31:0] addrs [4] = '{32'h0, 32'h44, 32'hFFC, 32'h200};
    logic [31:0] a;
    proc_write(32'h10, 32'hDEADBEEF);
    #1;
    checks++; if (data !== 32'hDEADBEEF) begin errors++; $display("FAIL proc_rw_first: got %h want deadbeef", data); end
    for (int i = 0; i < 4; i++) proc_write(addrs[i], $urandom());
    for (int i = 0; i < 4; i++) begin
      a = addrs[i];
      m_address = a;
      #1;
      checks++;
      if (data !== model[int'(a[AW+1:2])]) begin
        errors++; $display("FAIL proc_rw[%0d]: got %h want %h", i, data, model[int'(a[AW+1:2])]);
      end
    end
  endtask

  task automatic test_host_write();
    int lat;
    proc_write(32'h14, 32'h55555555);
    host_issue(1'b1, AW'(5), 32'h12345678);
    wait_ready(lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL host_write_ready_lat: got %0d want 1", lat); end
    checks++; if (data !== 32'h55555555) begin errors++; $display("FAIL host_write_old_data: got %h want 55555555", data); end
    tick();
    checks++; if (data !== 32'h12345678) begin errors++; $display("FAIL host_write_new_data: got %h want 12345678", data); end
  endtask

  task automatic test_host_read();
    int lat, rlat;
    logic [31:0] rd, exp;
    proc_write(32'h1C, 32'hA5A5A5A5);
    host_issue(1'b0, AW'(7), 32'h0);
    wait_ready(lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL host_read_ready_lat: got %0d want 1", lat); end
    wait_rvalid(rlat, rd);
    checks++; if (rlat != 1) begin errors++; $display("FAIL host_read_rvalid_lat: got %0d want 1", rlat); end
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL host_read_data: got %h with empty scoreboard", rd);
    end else begin
      exp = exp_q.pop_front();
      if (rd !== exp) begin errors++; $display("FAIL host_read_data: got %h want %h", rd, exp); end
    end
    tick();
    @(negedge clk);
    checks++; if (ld_rvalid !== 1'b0) begin errors++; $display("FAIL host_read_pulse: got %b want 0", ld_rvalid); end
  endtask

  task automatic test_back_to_back();
    int lat, rlat;
    logic [31:0] rd, exp;
    for (int i = 0; i < 4; i++) begin
      host_issue(1'b1, AW'(100 + 7 * i), $urandom());
      wait_ready(lat);
      checks++;
      if (lat != ((i == 0) ? 1 : 2)) begin
        errors++; $display("FAIL b2b_write_lat[%0d]: got %0d want %0d", i, lat, (i == 0) ? 1 : 2);
      end
    end
    for (int i = 0; i < 4; i++) begin
      host_issue(1'b0, AW'(100 + 7 * i), 32'h0);
      wait_ready(lat);
      checks++; if (lat != 2) begin errors++; $display("FAIL b2b_read_lat[%0d]: got %0d want 2", i, lat); end
      wait_rvalid(rlat, rd);
      checks++; if (rlat != 1) begin errors++; $display("FAIL b2b_rvalid_lat[%0d]: got %0d want 1", i, rlat); end
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL b2b_read_data[%0d]: got %h with empty scoreboard", i, rd);
      end else begin
        exp = exp_q.pop_front();
        if (rd !== exp) begin errors++; $display("FAIL b2b_read_data[%0d]: got %h want %h", i, rd, exp); end
      end
    end
    tick();
    @(negedge clk);
    checks++; if (ld_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_pulse: got %b want 0", ld_rvalid); end
  endtask

  task automatic test_collision();
    host_issue(1'b1, AW'(3), 32'hC0FFEE00);
    tick();
    memw_m = 1'b1; m_address = 32'hC; m_data = 32'h1;
    @(negedge clk);
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL coll_hold1: got %b want 0", ld_ready); end
    tick();
    @(negedge clk);
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL coll_hold2: got %b want 0", ld_ready); end
    checks++; if (data !== 32'h1) begin errors++; $display("FAIL coll_proc_data: got %h want 1", data); end
    tick();
    memw_m = 1'b0;
    @(negedge clk);
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL coll_retry_ready: got %b want 1", ld_ready); end
    checks++; if (data !== 32'h1) begin errors++; $display("FAIL coll_before_land: got %h want 1", data); end
    ld_valid = 1'b0;
    tick();
    checks++; if (data !== 32'hC0FFEE00) begin errors++; $display("FAIL coll_final: got %h want c0ffee00", data); end
  endtask

  task automatic test_addr_err();
    tick();
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL err_before: got %b want 0", addr_err); end
    memw_m = 1'b1; m_address = 32'h1000; m_data = 32'hFFFFFFFF;
    #1;
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL err_read_zero: got %h want 0", data); end
    tick();
    memw_m = 1'b0;
    @(negedge clk);
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", addr_err); end
    m_address = 32'h0;
    #1;
    checks++; if (data !== model[0]) begin errors++; $display("FAIL err_mem0: got %h want %h", data, model[0]); end
    m_address = 32'hFFC;
    #1;
    checks++; if (data !== model[1023]) begin errors++; $display("FAIL err_top_word: got %h want %h", data, model[1023]); end
    repeat (3) tick();
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", addr_err); end
  endtask

  task automatic test_reset_mid_read();
    int cnt0, lat, rlat;
    logic [31:0] rd, exp;
    tick();
    cnt0 = rvalid_count;
    host_issue(1'b0, AW'(7), 32'h0);
    tick();
    @(negedge clk);
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_grant: got %b want 1", ld_ready); end
    rst = 1'b0;
    ld_valid = 1'b0;
    void'(exp_q.pop_back());
    #1;
    checks++; if (ld_ready !== 1'b0)  begin errors++; $display("FAIL rst_mid_ready: got %b want 0", ld_ready); end
    checks++; if (ld_rvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_rvalid: got %b want 0", ld_rvalid); end
    checks++; if (ld_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_rdata: got %h want 0", ld_rdata); end
    checks++; if (addr_err !== 1'b0)  begin errors++; $display("FAIL rst_mid_addr_err: got %b want 0", addr_err); end
    repeat (3) tick();
    checks++; if (rvalid_count != cnt0) begin errors++; $display("FAIL rst_mid_no_rvalid: got %0d pulses want 0", rvalid_count - cnt0); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    host_issue(1'b0, AW'(7), 32'h0);
    wait_ready(lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL rst_after_ready_lat: got %0d want 1", lat); end
    wait_rvalid(rlat, rd);
    checks++; if (rlat != 1) begin errors++; $display("FAIL rst_after_rvalid_lat: got %0d want 1", rlat); end
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL rst_after_data: got %h with empty scoreboard", rd);
    end else begin
      exp = exp_q.pop_front();
      if (rd !== exp) begin errors++; $display("FAIL rst_after_data: got %h want %h", rd, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_proc_rw();
    test_host_write();
    test_host_read();
    test_back_to_back();
    test_collision();
    test_addr_err();
    test_reset_mid_read();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Responder for the processor's data-memory interface: a word-addressed RAM that serves the pipeline's Memory-stage accesses and gives a second, host-side load/readback port with a valid/ready handshake. Typical host use is preloading data or dumping results. The processor port cannot stall, so it always wins. The host port is serviced by a small FSM only in cycles the processor leaves free. The block sits outside the processor, beside instruction memory.

## Interface
Parameters:
- `DEPTH`, 1024: number of 32-bit words.
- `AW`, 10: word-index width, $clog2(DEPTH).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `memw_m`  in  1  processor write enable.
- `m_address`  in  32  processor byte address; word index = m_address[AW+1:2].
- `m_data`  in  32  processor write data.
- `data`  out  32  processor read data.
- `ld_valid`  in  1  host request valid.
- `ld_ready`  out  1  host request accepted this cycle.
- `ld_write`  in  1  1 = write request, 0 = read request.
- `ld_addr`  in  AW  host word index.
- `ld_wdata`  in  32  host write data.
- `ld_rvalid`  out  1  host read data valid; 1-cycle pulse.
- `ld_rdata`  out  32  host read data.
- `addr_err`  out  1  sticky flag: a processor address was out of range.

## Operation
- Processor read:
  - `data` = mem[m_address[AW+1:2]] combinationally, with no stall, as the Memory/Writeback pipe expects.
  - Out-of-range index (≥ DEPTH) returns 0.
- Processor write:
  - When `memw_m` = 1, mem[index] <= m_data at the clock edge.
  - An out-of-range write is dropped and sets `addr_err`.
- Host port FSM has three states:
  - IDLE → GRANT when `ld_valid` and !`memw_m`.
  - GRANT: `ld_ready` = 1 for exactly one cycle. The request is latched.
    - A write goes to mem[ld_addr] and returns to IDLE.
    - A read captures mem[ld_addr] into `ld_rdata` and goes to RESP.
  - RESP: `ld_rvalid` = 1 for one cycle, then IDLE.
- If `memw_m` rises while in GRANT:
  - A host write is held. The FSM stays in GRANT with `ld_ready` = 0.
  - The write retries the next cycle with `memw_m` = 0.
  - The latched request is kept; the host must not change it until `ld_ready`.
- Host reads never conflict with the processor; the array has two read ports.
- If a host write and a processor read hit the same word, `data` shows the old value until the write completes.
- `addr_err` is cleared only by reset.

## Timing
- Reset values:
  - FSM = IDLE.
  - `ld_ready` = 0, `ld_rvalid` = 0, `ld_rdata` = 0, `addr_err` = 0.
  - Memory contents are not cleared.
  - `data` follows the array combinationally.
- Reset asserted mid-transaction: the FSM returns to IDLE at once, any pending host write is discarded, and `ld_rvalid` drops the same instant.
- Host write latency: `ld_valid` seen in cycle N → `ld_ready` in N+1 → data visible on `data` from N+2 (if `memw_m` = 0 in N+1).
- Host read latency: `ld_ready` in N+1 → `ld_rvalid` and `ld_rdata` in N+2.
- Throughput: one host request per two cycles for writes, per three cycles for reads.
- Processor write → read of the same address in the next cycle returns the new value.

## Structure
- Shared package `mem_pkg`:
  - FSM state enum `ld_state_t` {IDLE, GRANT, RESP}.
  - `WORD_W` = 32.
  - Default `DEPTH`.
- One sub-module: `ram_2r1w`, the storage array.
  - Synchronous single write port, muxed between processor and host.
  - Two asynchronous read ports.
  - No reset.
- The top level holds the FSM, write arbitration and the range check.

## Test plan
- Processor write then read: memw_m=1, m_address=0x10, m_data=0xDEADBEEF; next cycle memw_m=0, same address → `data` = 0xDEADBEEF.
- Host write then processor read: ld_write=1, ld_addr=5, ld_wdata=0x12345678 with memw_m=0 → `ld_ready` one cycle later; m_address=0x14 then reads 0x12345678.
- Host read: mem[7]=0xA5A5A5A5, ld_write=0, ld_addr=7 → `ld_rvalid` pulses 2 cycles after `ld_valid`, with `ld_rdata` = 0xA5A5A5A5.
- Collision: host write to index 3 while memw_m=1 to index 3 (m_data=0x1) for two cycles → `ld_ready` stays 0. The host value lands after memw_m drops, and final mem[3] = the host value.
- Out of range with DEPTH=1024: memw_m=1, m_address=0x1000 → `addr_err` = 1 and stays set; mem[0] unchanged; `data` = 0 at that address.
- Reset mid-read: drop rst while in GRANT with a read latched → `ld_rvalid` never pulses; all outputs return to 0; the FSM accepts a new request after rst goes high again.
